// File: rtl/ldpc_llr_framer.sv
// ldpc_llr_framer
//   Upstream stage of ldpc_decoder. Collects N channel LLR samples from a
//   valid/ready stream into the decoder's packed lambda frame, strobes
//   lambda_valid for one cycle, then stalls until the decoder signals done.
//   Frame delineation is checked against in_last; malformed frames are
//   dropped with a one-cycle frame_err strobe.
//
// Configuration macro:
//   LDPC_LLR_SAT_EN  defined   : in_data saturated to the LLR_W signed range
//                    undefined : in_data truncated to its low LLR_W bits
//
// Ports:
//   clk           in   clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   in_valid      in   input sample valid
//   in_ready      out  framer can accept a sample (FILL state)
//   in_data       in   LLR_IN_W signed sample
//   in_last       in   final sample of a frame
//   lambda_valid  out  1-cycle strobe, lambda holds a complete frame
//   lambda        out  N*LLR_W packed frame, LLR k at [k*LLR_W +: LLR_W]
//   dec_done      in   decoder finished current frame (honoured in WAIT only)
//   busy          out  frame issued, waiting for dec_done
//   frame_err     out  1-cycle strobe, malformed frame dropped
//   frame_cnt     out  CNT_W count of issued frames, wraps

module ldpc_llr_framer #(
  parameter int N        = 12,
  parameter int LLR_W    = 6,
  parameter int LLR_IN_W = 8,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LLR_IN_W-1:0]  in_data,
  input  logic                 in_last,
  output logic                 lambda_valid,
  output logic [N*LLR_W-1:0]   lambda,
  input  logic                 dec_done,
  output logic                 busy,
  output logic                 frame_err,
  output logic [CNT_W-1:0]     frame_cnt
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t               state_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 drop_q;
  logic                 in_ready_q;
  logic                 lambda_valid_q;
  logic                 busy_q;
  logic                 frame_err_q;
  logic [CNT_W-1:0]     frame_cnt_q;
  logic [N*LLR_W-1:0]   lambda_q;
  logic [LLR_W-1:0]     sample_d;
  logic                 beat;

  // Width conversion of the incoming sample.
`ifdef LDPC_LLR_SAT_EN
  localparam logic signed [LLR_IN_W-1:0] SAT_MAX = LLR_IN_W'((2 ** (LLR_W - 1)) - 1);
  localparam logic signed [LLR_IN_W-1:0] SAT_MIN = LLR_IN_W'(-(2 ** (LLR_W - 1)));

  always_comb begin
    sample_d = in_data[LLR_W-1:0];
    if ($signed(in_data) > SAT_MAX) begin
      sample_d = SAT_MAX[LLR_W-1:0];
    end else if ($signed(in_data) < SAT_MIN) begin
      sample_d = SAT_MIN[LLR_W-1:0];
    end
  end
`else
  logic unused_in_msbs;
  assign unused_in_msbs = ^in_data;

  always_comb begin
    sample_d = in_data[LLR_W-1:0];
  end
`endif

  assign beat = in_valid && in_ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_FILL;
      idx_q          <= '0;
      drop_q         <= 1'b0;
      in_ready_q     <= 1'b1;
      lambda_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      frame_err_q    <= 1'b0;
      frame_cnt_q    <= '0;
      lambda_q       <= '0;
    end else begin
      lambda_valid_q <= 1'b0;
      frame_err_q    <= 1'b0;
      case (state_q)
        S_FILL: begin
          if (beat) begin
            if (drop_q) begin
              // Overlong frame: swallow beats up to and including in_last.
              if (in_last) begin
                drop_q <= 1'b0;
              end
            end else begin
              for (int unsigned k = 0; k < N; k++) begin
                if (idx_q == IDX_W'(k)) begin
                  lambda_q[k*LLR_W +: LLR_W] <= sample_d;
                end
              end
              if (idx_q == LAST_IDX) begin
                idx_q <= '0;
                if (in_last) begin
                  state_q        <= S_ISSUE;
                  in_ready_q     <= 1'b0;
                  lambda_valid_q <= 1'b1;
                end else begin
                  frame_err_q <= 1'b1;
                  drop_q      <= 1'b1;
                end
              end else if (in_last) begin
                idx_q       <= '0;
                frame_err_q <= 1'b1;
              end else begin
                idx_q <= idx_q + 1'b1;
              end
            end
          end
        end
        S_ISSUE: begin
          frame_cnt_q <= frame_cnt_q + 1'b1;
          busy_q      <= 1'b1;
          state_q     <= S_WAIT;
        end
        S_WAIT: begin
          if (dec_done) begin
            busy_q     <= 1'b0;
            in_ready_q <= 1'b1;
            state_q    <= S_FILL;
          end
        end
        default: begin
          state_q    <= S_FILL;
          idx_q      <= '0;
          drop_q     <= 1'b0;
          busy_q     <= 1'b0;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign lambda_valid = lambda_valid_q;
  assign lambda       = lambda_q;
  assign busy         = busy_q;
  assign frame_err    = frame_err_q;
  assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_ldpc_llr_framer.sv
module tb_ldpc_llr_framer;

  localparam int N  = 12;
  localparam int W  = 6;
  localparam int IW = 8;
`ifdef LDPC_LLR_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_last = 1'b0;
  logic            dec_done = 1'b0;
  logic [IW-1:0]   in_data = '0;

  logic            in_ready, lambda_valid, busy, frame_err;
  logic [N*W-1:0]  lambda;
  logic [15:0]     frame_cnt;
  logic            in_ready2, lambda_valid2, busy2, frame_err2;
  logic [N*W-1:0]  lambda2;
  logic [1:0]      frame_cnt2;

  always #5 clk = ~clk;

  ldpc_llr_framer #(.N(N), .LLR_W(W), .LLR_IN_W(IW), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .lambda_valid(lambda_valid),
    .lambda(lambda), .dec_done(dec_done), .busy(busy),
    .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  ldpc_llr_framer #(.N(N), .LLR_W(W), .LLR_IN_W(IW), .CNT_W(2)) u_dut_c2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_last(in_last), .lambda_valid(lambda_valid2),
    .lambda(lambda2), .dec_done(dec_done), .busy(busy2),
    .frame_err(frame_err2), .frame_cnt(frame_cnt2)
  );

  int tests = 0;
  int fails = 0;
  int err_pulses = 0;
  logic [N*W-1:0] sb_q[$];

  task automatic chk(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference conversion of one input sample to decoder width.
  function automatic logic [W-1:0] conv(input logic [IW-1:0] d);
    int v;
    v = int'($signed(d));
    if (SAT && v > 31)  return 6'h1F;
    if (SAT && v < -32) return 6'h20;
    return d[W-1:0];
  endfunction

  // Scoreboard: every lambda_valid must match the oldest expected frame.
  always @(negedge clk) begin
    logic [N*W-1:0] e;
    if (rst_n) begin
      if (frame_err) err_pulses++;
      if (lambda_valid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_lambda_valid", 1'b1, 1'b0);
        end else begin
          e = sb_q.pop_front();
          chk("lambda", lambda, e);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send(input logic [IW-1:0] d, input logic l);
    int unsigned n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = l;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 1'b0, 1'b1);
    @(posedge clk);
  endtask

  task automatic send_frame(input logic [IW-1:0] b[N], input logic [N*W-1:0] e);
    sb_q.push_back(e);
    for (int k = 0; k < N; k++) send(b[k], k == N - 1);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    chk("latency_lambda_valid", lambda_valid, 1'b1);
    chk("issue_in_ready", in_ready, 1'b0);
  endtask

  task automatic rand_frame();
    logic [IW-1:0]  b[N];
    logic [N*W-1:0] e;
    e = '0;
    for (int k = 0; k < N; k++) begin
      b[k] = IW'($urandom);
      e[k*W +: W] = conv(b[k]);
    end
    send_frame(b, e);
  endtask

  // Hold in_valid high in WAIT, then release the framer with dec_done.
  task automatic release_dec(input int hold, input logic [15:0] c1, input logic [1:0] c2);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'h11; in_last = 1'b0;
      chk("wait_in_ready", in_ready, 1'b0);
    end
    chk("wait_busy", busy, 1'b1);
    chk("frame_cnt", frame_cnt, c1);
    chk("frame_cnt_w2", frame_cnt2, c2);
    @(negedge clk);
    in_valid = 1'b0; dec_done = 1'b1;
    @(negedge clk);
    dec_done = 1'b0;
    chk("done_in_ready", in_ready, 1'b1);
    chk("done_busy", busy, 1'b0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    chk({tag, "_lambda_valid"}, lambda_valid, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_frame_err"}, frame_err, 1'b0);
    chk({tag, "_frame_cnt"}, frame_cnt, 16'd0);
    chk({tag, "_lambda"}, lambda, '0);
  endtask

  typedef struct {
    logic [IW-1:0] din;
    logic [W-1:0]  exp;
  } vec_t;

  initial begin
    vec_t           vt[2*N];
    logic [IW-1:0]  b[N];
    logic [N*W-1:0] e;
    int             ncnt;
    int             e0;

    // Frame 0: in-range values; frame 1: saturation/truncation corners.
    vt[0]  = '{8'h0C, 6'h0C}; vt[1]  = '{8'hEF, 6'h2F}; vt[2]  = '{8'h0A, 6'h0A};
    vt[3]  = '{8'h10, 6'h10}; vt[4]  = '{8'h0A, 6'h0A}; vt[5]  = '{8'hF5, 6'h35};
    vt[6]  = '{8'hFF, 6'h3F}; vt[7]  = '{8'hFA, 6'h3A}; vt[8]  = '{8'h0E, 6'h0E};
    vt[9]  = '{8'hE9, 6'h29}; vt[10] = '{8'h14, 6'h14}; vt[11] = '{8'hFC, 6'h3C};
    vt[12] = '{8'h50, SAT ? 6'h1F : 6'h10};
    vt[13] = '{8'hA0, 6'h20};
    vt[14] = '{8'h7F, SAT ? 6'h1F : 6'h3F};
    vt[15] = '{8'h80, SAT ? 6'h20 : 6'h00};
    vt[16] = '{8'h1F, 6'h1F};
    vt[17] = '{8'hE0, 6'h20};
    vt[18] = '{8'h20, SAT ? 6'h1F : 6'h20};
    vt[19] = '{8'hDF, SAT ? 6'h20 : 6'h1F};
    vt[20] = '{8'h00, 6'h00};
    vt[21] = '{8'hFF, 6'h3F};
    vt[22] = '{8'h05, 6'h05};
    vt[23] = '{8'hFB, 6'h3B};

    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;

    ncnt = 0;
    for (int f = 0; f < 2; f++) begin
      e = '0;
      for (int k = 0; k < N; k++) begin
        b[k] = vt[f*N + k].din;
        e[k*W +: W] = vt[f*N + k].exp;
      end
      send_frame(b, e);
      if (f == 0) chk("lambda_literal", lambda, 72'hF14A4EEBFD4A40ABCC);
      ncnt++;
      release_dec(10, 16'(ncnt), 2'(ncnt));
    end

    // Short frame: in_last on the 5th beat.
    for (int k = 0; k < 5; k++) send(IW'($urandom), k == 4);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    chk("short_frame_err", frame_err, 1'b1);
    chk("short_no_lambda_valid", lambda_valid, 1'b0);
    @(negedge clk);
    chk("short_err_pulse_1cyc", frame_err, 1'b0);
    chk("short_in_ready", in_ready, 1'b1);
    rand_frame();
    ncnt++;
    release_dec(1, 16'(ncnt), 2'(ncnt));

    // Long frame: 12 beats without in_last, then 3 discarded, last with in_last.
    e0 = err_pulses;
    for (int k = 0; k < N; k++) send(IW'($urandom), 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("long_frame_err", frame_err, 1'b1);
    for (int k = 0; k < 3; k++) send(IW'($urandom), k == 2);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    chk("long_err_count", 72'(err_pulses - e0), 72'd1);
    chk("long_no_lambda_valid", lambda_valid, 1'b0);
    rand_frame();
    ncnt++;
    release_dec(1, 16'(ncnt), 2'(ncnt));

    // Reset after 7 beats.
    for (int k = 0; k < 7; k++) send(IW'($urandom), 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_midframe");
    @(negedge clk);
    rst_n = 1'b1;
    rand_frame();
    release_dec(2, 16'd1, 2'd1);

    // Reset while waiting for dec_done.
    rand_frame();
    @(negedge clk);
    chk("pre_rst_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_wait");
    @(negedge clk);
    rst_n = 1'b1;

    // Five frames: 16-bit count 1..5, 2-bit count wraps 1,2,3,0,1.
    for (int i = 1; i <= 5; i++) begin
      rand_frame();
      release_dec(1, 16'(i), 2'(i));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 72'(sb_q.size()), 72'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
